fft_frame_ring_buffer: RTL and testbench
========================================

Name: fft_frame_ring_buffer

Overview:
- Circular sample store directly upstream of the FFT data port.
- Continuously captures ADC samples on sample_valid.
- On a rising edge of send_frame from the FFT controller, replays the most recent FRAME_LEN samples, oldest first, as an AXI4-Stream frame.
- Output words are complex and FFT-formatted: imaginary = 0, real = sign-extended sample. tlast marks the final beat.

Parameters:
- DATA_W, 16, sample width in bits (two's complement).
- ADDR_W, 10, buffer address width; FRAME_LEN = DEPTH = 2**ADDR_W.
- TDATA_W, 32, m_axis_tdata width; must be ≥ 2*DATA_W, even.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  ADC sample.
- sample_valid  in  1  single-cycle strobe; write sample_in this cycle.
- send_frame  in  1  frame request level from the FFT controller; rising edge starts a frame.
- m_axis_tready  in  1  FFT data ready.
- m_axis_tdata  out  TDATA_W  {imag[TDATA_W/2-1:0]=0, real = sign-extended sample}.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  last beat of frame.
- buffer_full  out  1  at least FRAME_LEN samples captured since reset.
- frame_busy  out  1  frame replay in progress.
- overrun  out  1  sticky: the writer overwrote an unread sample during replay.

Behaviour:
- Reset (async, reset_b low), all registers clear:
  - wr_ptr = 0, fill_cnt = 0, state = IDLE.
  - m_axis_tvalid, m_axis_tlast, frame_busy, overrun, buffer_full = 0; m_axis_tdata = 0.
  - RAM contents are not reset.
- Write side, independent of read state:
  - sample_valid=1: mem[wr_ptr] <= sample_in; wr_ptr wraps modulo DEPTH.
  - fill_cnt saturates at DEPTH; buffer_full = (fill_cnt == DEPTH).
- Request detect:
  - req = send_frame & ~send_frame_q.
  - In any state other than IDLE, req is ignored.
  - In IDLE with buffer_full=0, req is ignored; no output, no flag.
- Memory: synchronous read, 1-cycle latency.
- State machine:
  - IDLE:
    - On req & buffer_full: rd_ptr <= wr_ptr (oldest sample; equals wr_ptr+1 if sample_valid is coincident), beats_left <= DEPTH, overrun <= 0, go to PRIME.
  - PRIME:
    - Issue read at rd_ptr; go to LOAD.
  - LOAD:
    - Capture RAM data into the output register; m_axis_tvalid <= 1.
    - m_axis_tlast <= (beats_left == 1); advance rd_ptr; issue next read; go to STREAM.
  - STREAM: the output register holds the current beat; one look-ahead word is held in a skid register.
    - On tvalid & tready: load the next word from the skid register or RAM and decrement beats_left.
    - tlast is asserted only with beat DEPTH.
    - On handshake of the tlast beat: tvalid <= 0, tlast <= 0, go to IDLE.
    - tdata/tvalid/tlast hold stable while tready=0 (AXI rule).
    - Zero-bubble throughput with tready held high: 1 beat/clk.
- frame_busy = 1 in PRIME, LOAD and STREAM.
- Latency: req seen in cycle T → first tvalid in cycle T+3; full frame completes in T+3+DEPTH cycles with tready held high.
- Overrun:
  - During replay, if sample_valid writes the address of a sample not yet read out, set overrun (sticky until the next frame start).
  - The write still occurs; replay continues and emits whatever is in RAM.
- Simultaneous write and read of the same address: read returns the old data (read-first).
- Reset mid-frame: immediate abort; tvalid drops asynchronously, fill_cnt clears, and buffer_full must be re-earned.

Optional Feature:
- FRAME_TAG_EN defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments (wrapping) on each tlast handshake.
  - Adds output frame_dropped (1 bit), a 1-cycle pulse when a req is ignored because buffer_full=0 or frame_busy=1.
- FRAME_TAG_EN undefined: both ports and their logic are absent.

Test Plan:
- Reset, then 1024 samples 0..1023, then a send_frame pulse with tready=1 → tvalid at T+3, 1024 beats with real=0..1023, imag=0, tlast only on the beat with value 1023, frame_busy then drops.
- 1500 samples (value = index), then a frame → beats 476..1499 in order, confirming wrap-around handling.
- Same as the first test with tready toggled pseudo-randomly → identical data sequence, no dropped or duplicated beats, tdata stable while tready=0.
- send_frame after only 500 samples → no tvalid, frame_busy=0; with FRAME_TAG_EN, frame_dropped pulses once.
- Frame with tready=0 for 300 cycles mid-frame while sample_valid strobes every cycle → overrun=1; overrun clears at the next frame start.
- Assert reset_b low on beat 200 → tvalid=0 and buffer_full=0 immediately; a later send_frame is ignored until 1024 new samples have been captured.

Source files
------------

// File: rtl/fft_frame_ring_buffer.sv
// Circular ADC sample store; on a send_frame rising edge replays the newest DEPTH samples oldest-first as an AXI4-Stream frame.
// Latency: req in cycle T -> first tvalid in T+3, then 1 beat/clk. Backpressure: output reg + one-word skid, RAM reads throttled by tready.
// Optional FRAME_TAG_EN adds frame_count and frame_dropped outputs.
module fft_frame_ring_buffer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int TDATA_W = 32
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic               sample_valid,
    input  logic               send_frame,
    input  logic               m_axis_tready,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    output logic               buffer_full,
    output logic               frame_busy,
    output logic               overrun
`ifdef FRAME_TAG_EN
    ,
    output logic [15:0]        frame_count,
    output logic               frame_dropped
`endif
);

    localparam int HALF = TDATA_W / 2;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, PRIME, LOAD, STREAM} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   ram_dat, skid_dat, nxt_dat;
    logic                ram_vld, skid_vld;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr, wr_dist;
    logic [ADDR_W:0]     fill_cnt, reads_left, beats_left, unread;
    logic                send_frame_q, req, start, hs, rd_issue, ov_hit;

    assign req         = send_frame & ~send_frame_q;
    assign buffer_full = (fill_cnt == DEPTH);
    assign frame_busy  = (state_q != IDLE);
    assign start       = (state_q == IDLE) & req & buffer_full;
    assign hs          = m_axis_tvalid & m_axis_tready;
    assign nxt_dat     = skid_vld ? skid_dat : ram_dat;

    // A write hits an unread sample if it lands inside the window still to be fetched after this cycle's read.
    assign wr_dist = wr_ptr - rd_ptr - ADDR_W'(rd_issue);
    assign unread  = reads_left - (ADDR_W+1)'(rd_issue);
    assign ov_hit  = frame_busy & sample_valid & ({1'b0, wr_dist} < unread);

    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = PRIME;
            PRIME:  begin rd_issue = 1'b1; state_d = LOAD; end
            LOAD:   begin rd_issue = 1'b1; state_d = STREAM; end
            STREAM: begin
                // Only fetch when the word arriving next cycle is guaranteed a slot.
                rd_issue = (reads_left != '0) &&
                           (({1'b0, skid_vld} + {1'b0, ram_vld}) <= {1'b0, hs});
                if (hs && m_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-first on a same-address collision falls out of the nonblocking update.
    always_ff @(posedge clk) begin
        if (sample_valid) mem[wr_ptr] <= sample_in;
        if (rd_issue)     ram_dat     <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= IDLE;
            send_frame_q  <= 1'b0;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            rd_ptr        <= '0;
            reads_left    <= '0;
            beats_left    <= '0;
            ram_vld       <= 1'b0;
            skid_vld      <= 1'b0;
            skid_dat      <= '0;
            overrun       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state_q      <= state_d;
            send_frame_q <= send_frame;
            ram_vld      <= rd_issue;
            if (sample_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill_cnt != DEPTH) fill_cnt <= fill_cnt + 1'b1;
            end
            if (start) begin
                rd_ptr     <= sample_valid ? wr_ptr + 1'b1 : wr_ptr;
                reads_left <= DEPTH;
                beats_left <= DEPTH;
                overrun    <= 1'b0;
                skid_vld   <= 1'b0;
            end else begin
                if (rd_issue) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    reads_left <= reads_left - 1'b1;
                end
                if (ov_hit) overrun <= 1'b1;
            end
            case (state_q)
                LOAD: begin
                    m_axis_tdata  <= {{HALF{1'b0}}, HALF'(signed'(ram_dat))};
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (beats_left == (ADDR_W+1)'(1));
                end
                STREAM: begin
                    if (hs && m_axis_tlast) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end else if (hs) begin
                        m_axis_tdata <= {{HALF{1'b0}}, HALF'(signed'(nxt_dat))};
                        m_axis_tlast <= (beats_left == (ADDR_W+1)'(2));
                        beats_left   <= beats_left - 1'b1;
                        if (skid_vld) begin
                            if (ram_vld) skid_dat <= ram_dat;
                            else         skid_vld <= 1'b0;
                        end
                    end else if (ram_vld) begin
                        skid_dat <= ram_dat;
                        skid_vld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_TAG_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            frame_count   <= '0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= req & (frame_busy | ~buffer_full);
            if (hs && m_axis_tlast) frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ring_buffer.sv
// Directed bench for fft_frame_ring_buffer: fill patterns, wrap, backpressure, underfill, overrun and mid-frame reset.
module tb_fft_frame_ring_buffer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int TDATA_W = 32;
    localparam int DEPTH   = 1024;

    logic               clk = 1'b0;
    logic               reset_b;
    logic [DATA_W-1:0]  sample_in;
    logic               sample_valid;
    logic               send_frame;
    logic               m_axis_tready;
    logic [TDATA_W-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic               buffer_full;
    logic               frame_busy;
    logic               overrun;
`ifdef FRAME_TAG_EN
    logic [15:0]        frame_count;
    logic               frame_dropped;
`endif

    int n_vec = 0;
    int n_err = 0;

    fft_frame_ring_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TDATA_W(TDATA_W)) dut (
`ifdef FRAME_TAG_EN
        .frame_count   (frame_count),
        .frame_dropped (frame_dropped),
`endif
        .clk           (clk),
        .reset_b       (reset_b),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .send_frame    (send_frame),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .buffer_full   (buffer_full),
        .frame_busy    (frame_busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_samples(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in    = DATA_W'(base + i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    // Raises send_frame in cycle T and checks the T+1..T+3 startup sequence.
    task automatic pulse_req(input string tag);
        send_frame = 1'b1;
        tick();
        chk({tag, "_busy_t1"}, 32'(frame_busy), 32'd1);
        chk({tag, "_ovr_clr_t1"}, 32'(overrun), 32'd0);
        chk({tag, "_tvalid_t1"}, 32'(m_axis_tvalid), 32'd0);
        send_frame = 1'b0;
        tick();
        chk({tag, "_tvalid_t2"}, 32'(m_axis_tvalid), 32'd0);
        tick();
        chk({tag, "_tvalid_t3"}, 32'(m_axis_tvalid), 32'd1);
    endtask

    // mode 0: tready=1; 1: random tready; 2: 300-cycle stall at beat 100 with samples strobing.
    task automatic collect(input int mode, input int first_val, input int abort_at,
                           output int beats, output int bad_data, output int bad_last,
                           output int unstable, output int cycles);
        int stall = 0;
        bit prev_stall = 1'b0;
        logic [TDATA_W-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        int expv;
        beats = 0; bad_data = 0; bad_last = 0; unstable = 0; cycles = -1;
        for (int c = 0; c < 6000; c++) begin
            if (abort_at != 0 && beats == abort_at) break;
            case (mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: begin
                    if (beats == 100 && stall < 300) begin
                        m_axis_tready = 1'b0;
                        sample_valid  = 1'b1;
                        sample_in     = DATA_W'(16'h5000 + stall);
                        stall++;
                    end else begin
                        m_axis_tready = 1'b1;
                        sample_valid  = 1'b0;
                    end
                end
            endcase
            if (prev_stall && (m_axis_tdata !== prev_d || m_axis_tlast !== prev_l || m_axis_tvalid !== 1'b1))
                unstable++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                expv = first_val + beats;
                if (m_axis_tdata !== {16'h0000, 16'(expv)}) bad_data++;
                if (m_axis_tlast !== (beats == DEPTH - 1)) bad_last++;
                beats++;
                cycles = c;
            end
            tick();
            if (beats == DEPTH) break;
        end
        m_axis_tready = 1'b0;
        sample_valid  = 1'b0;
    endtask

    // Watches 10 cycles after a request that must be ignored.
    task automatic ignored_req(input string tag);
        int nv = 0;
        int nb = 0;
        int nd = 0;
        m_axis_tready = 1'b1;
        send_frame = 1'b1;
        tick();
        send_frame = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid) nv++;
            if (frame_busy) nb++;
`ifdef FRAME_TAG_EN
            if (frame_dropped) nd++;
`endif
            tick();
        end
        m_axis_tready = 1'b0;
        chk({tag, "_no_tvalid"}, 32'(nv), 32'd0);
        chk({tag, "_no_busy"}, 32'(nb), 32'd0);
`ifdef FRAME_TAG_EN
        chk({tag, "_dropped_once"}, 32'(nd), 32'd1);
`else
        nd = 0;
`endif
    endtask

    initial begin
        int beats, bad_d, bad_l, unst, cyc;

        reset_b = 1'b0; sample_in = '0; sample_valid = 1'b0; send_frame = 1'b0; m_axis_tready = 1'b0;
        tick();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_full", 32'(buffer_full), 32'd0);
        tick();
        reset_b = 1'b1;
        tick();

        // Linear fill, no backpressure
        write_samples(0, DEPTH - 1);
        chk("full_at_1023", 32'(buffer_full), 32'd0);
        write_samples(DEPTH - 1, 1);
        chk("full_at_1024", 32'(buffer_full), 32'd1);
        pulse_req("f1");
        collect(0, 0, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f1_beats", 32'(beats), 32'(DEPTH));
        chk("f1_data_err", 32'(bad_d), 32'd0);
        chk("f1_tlast_err", 32'(bad_l), 32'd0);
        chk("f1_last_cycle", 32'(cyc), 32'(DEPTH - 1));
        chk("f1_busy_after", 32'(frame_busy), 32'd0);
        chk("f1_tvalid_after", 32'(m_axis_tvalid), 32'd0);
`ifdef FRAME_TAG_EN
        chk("f1_frame_count", 32'(frame_count), 32'd1);
`endif

        // Wrap-around: 1500 samples, newest 1024 are 476..1499
        write_samples(0, 1500);
        pulse_req("f2");
        collect(0, 476, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f2_beats", 32'(beats), 32'(DEPTH));
        chk("f2_data_err", 32'(bad_d), 32'd0);
        chk("f2_tlast_err", 32'(bad_l), 32'd0);

        // Random backpressure
        write_samples(0, DEPTH);
        pulse_req("f3");
        collect(1, 0, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f3_beats", 32'(beats), 32'(DEPTH));
        chk("f3_data_err", 32'(bad_d), 32'd0);
        chk("f3_tlast_err", 32'(bad_l), 32'd0);
        chk("f3_unstable", 32'(unst), 32'd0);

        // Overrun during a long stall; next frame start clears it
        pulse_req("f4");
        collect(2, 0, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f4_beats", 32'(beats), 32'(DEPTH));
        chk("f4_unstable", 32'(unst), 32'd0);
        chk("f4_overrun", 32'(overrun), 32'd1);
        pulse_req("f5");
        collect(0, 0, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f5_beats", 32'(beats), 32'(DEPTH));

        // Underfilled request is ignored
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        tick();
        write_samples(0, 500);
        ignored_req("u1");
        chk("u1_full", 32'(buffer_full), 32'd0);

        // Reset at beat 200 aborts immediately
        write_samples(500, DEPTH - 500);
        pulse_req("f6");
        collect(0, 0, 200, beats, bad_d, bad_l, unst, cyc);
        chk("f6_beats_before_rst", 32'(beats), 32'd200);
        chk("f6_data_err", 32'(bad_d), 32'd0);
        reset_b = 1'b0;
        #1;
        chk("f6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("f6_rst_full", 32'(buffer_full), 32'd0);
        chk("f6_rst_busy", 32'(frame_busy), 32'd0);
        tick();
        reset_b = 1'b1;
        tick();
        write_samples(3000, 500);
        ignored_req("u2");
        write_samples(3500, DEPTH - 500);
        chk("f7_full", 32'(buffer_full), 32'd1);
        pulse_req("f7");
        collect(0, 3000, 0, beats, bad_d, bad_l, unst, cyc);
        chk("f7_beats", 32'(beats), 32'(DEPTH));
        chk("f7_data_err", 32'(bad_d), 32'd0);
        chk("f7_tlast_err", 32'(bad_l), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
